// File: rtl/uart_frame_packer.sv
// ============================================================================
// Module  : uart_frame_packer
// Brief   : Buffers tagged samples and emits each one as a framed UART byte stream.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_frame_packer #(
  parameter int         SAMPLE_W     = 12,
  parameter int         CHAN_W       = 2,
  parameter int         FIFO_DEPTH   = 8,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         ADD_CHECKSUM = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          sample_valid,
  input  logic [SAMPLE_W-1:0]           sample_data,
  input  logic [CHAN_W-1:0]             sample_chan,
  output logic                          sample_ready,
  output logic                          uart_tx_en,
  output logic [7:0]                    uart_tx_data,
  input  logic                          uart_tx_busy,
  output logic                          frame_busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int NBYTES  = (SAMPLE_W + 7) / 8;
  localparam int DATA_W  = NBYTES * 8;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int LVL_W   = AW + 1;
  localparam int ENTRY_W = CHAN_W + SAMPLE_W;

  localparam logic [3:0]       c_LAST_DATA = 4'(1 + NBYTES);
  localparam logic [3:0]       c_LAST_IDX  = 4'(1 + NBYTES + ADD_CHECKSUM);
  localparam logic [LVL_W-1:0] c_DEPTH     = LVL_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_SEND      = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_WAIT_IDLE = 3'd4
  } state_t;

  state_t              r_state;
  logic [ENTRY_W-1:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0]       r_wptr;
  logic [AW-1:0]       r_rptr;
  logic [LVL_W-1:0]    r_level;
  logic                r_overflow;
  logic [3:0]          r_seq;
  logic [3:0]          r_chan4;
  logic [DATA_W-1:0]   r_shift;
  logic [7:0]          r_csum;
  logic [3:0]          r_idx;
  logic                r_en;
  logic [7:0]          r_txd;

  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic [ENTRY_W-1:0]  w_head;
  logic [DATA_W-1:0]   w_data_ext;
  logic [3:0]          w_chan4;
  logic [7:0]          w_csum;
  logic [7:0]          w_cur_byte;

  assign w_full  = (r_level == c_DEPTH);
  assign w_empty = (r_level == '0);
  assign w_push  = sample_valid && !w_full;
  assign w_pop   = (r_state == S_LOAD);
  assign w_head  = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {sample_chan, sample_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (sample_valid && w_full) r_overflow <= 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Checksum covers header and data bytes; seq is frozen for the whole frame.
  always_comb begin
    w_data_ext                 = '0;
    w_data_ext[SAMPLE_W-1:0]   = w_head[SAMPLE_W-1:0];
    w_chan4                    = '0;
    w_chan4[CHAN_W-1:0]        = w_head[ENTRY_W-1 -: CHAN_W];
    w_csum                     = {r_seq, w_chan4};
    for (int i = 0; i < NBYTES; i++) begin
      w_csum = w_csum ^ w_data_ext[i*8 +: 8];
    end
  end

  always_comb begin
    w_cur_byte = r_csum;
    if (r_idx == 4'd0) begin
      w_cur_byte = SYNC_BYTE;
    end else if (r_idx == 4'd1) begin
      w_cur_byte = {r_seq, r_chan4};
    end else if (r_idx <= c_LAST_DATA) begin
      w_cur_byte = r_shift[DATA_W-1 -: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_seq   <= '0;
      r_chan4 <= '0;
      r_shift <= '0;
      r_csum  <= '0;
      r_idx   <= '0;
      r_en    <= 1'b0;
      r_txd   <= '0;
    end else begin
      r_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (enable && !w_empty) r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_chan4 <= w_chan4;
          r_shift <= w_data_ext;
          r_csum  <= w_csum;
          r_idx   <= '0;
          // The sync byte is constant, so it can launch on the load edge.
          if (!uart_tx_busy) begin
            r_txd   <= SYNC_BYTE;
            r_en    <= 1'b1;
            r_state <= S_WAIT_BUSY;
          end else begin
            r_state <= S_SEND;
          end
        end
        S_SEND: begin
          if (!uart_tx_busy) begin
            r_txd   <= w_cur_byte;
            r_en    <= 1'b1;
            if (r_idx >= 4'd2 && r_idx <= c_LAST_DATA) r_shift <= r_shift << 8;
            r_state <= S_WAIT_BUSY;
          end
        end
        S_WAIT_BUSY: begin
          if (uart_tx_busy) r_state <= S_WAIT_IDLE;
        end
        S_WAIT_IDLE: begin
          if (!uart_tx_busy) begin
            if (r_idx == c_LAST_IDX) begin
              r_seq   <= r_seq + 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= S_SEND;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sample_ready = !w_full;
  assign uart_tx_en   = r_en;
  assign uart_tx_data = r_txd;
  assign frame_busy   = (r_state != S_IDLE);
  assign overflow     = r_overflow;
  assign fifo_level   = r_level;

endmodule

`default_nettype wire

// File: tb/tb_uart_frame_packer.sv
// ============================================================================
// Module  : tb_uart_frame_packer
// Brief   : Scoreboard bench for uart_frame_packer with a uart_tx busy model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_frame_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        sample_valid;
  logic [11:0] sample_data;
  logic [1:0]  sample_chan;
  logic        sample_ready;
  logic        uart_tx_en;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_busy;
  logic        frame_busy;
  logic        overflow;
  logic [3:0]  fifo_level;

  logic        v20;
  logic [19:0] d20;
  logic [1:0]  c20;
  logic        ready20;
  logic        en20;
  logic [7:0]  data20;
  logic        busy20;
  logic        fb20;
  logic        ovf20;
  logic [3:0]  lvl20;

  int          tests = 0;
  int          fails = 0;
  int          en_count = 0;
  int          pulses = 0;
  logic        prev_busy = 1'b0;
  logic [3:0]  m_seq = 4'd0;
  logic [7:0]  q[$];
  logic [7:0]  q20[$];
  int          hold;
  int          hold20;

  always #5 clk = ~clk;

  uart_frame_packer #(
    .SAMPLE_W(12), .CHAN_W(2), .FIFO_DEPTH(8), .SYNC_BYTE(8'hA5), .ADD_CHECKSUM(1)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .sample_valid(sample_valid), .sample_data(sample_data), .sample_chan(sample_chan),
    .sample_ready(sample_ready), .uart_tx_en(uart_tx_en), .uart_tx_data(uart_tx_data),
    .uart_tx_busy(uart_tx_busy), .frame_busy(frame_busy), .overflow(overflow),
    .fifo_level(fifo_level)
  );

  uart_frame_packer #(
    .SAMPLE_W(20), .CHAN_W(2), .FIFO_DEPTH(8), .SYNC_BYTE(8'hA5), .ADD_CHECKSUM(0)
  ) dut20 (
    .clk(clk), .rst(rst), .enable(enable),
    .sample_valid(v20), .sample_data(d20), .sample_chan(c20),
    .sample_ready(ready20), .uart_tx_en(en20), .uart_tx_data(data20),
    .uart_tx_busy(busy20), .frame_busy(fb20), .overflow(ovf20),
    .fifo_level(lvl20)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // uart_tx stand-in: busy rises the cycle after an en pulse and holds 87 cycles.
  always @(posedge clk) begin
    if (rst) begin
      uart_tx_busy <= 1'b0;
      hold         <= 0;
    end else if (uart_tx_busy) begin
      if (hold == 1) uart_tx_busy <= 1'b0;
      hold <= hold - 1;
    end else if (uart_tx_en) begin
      uart_tx_busy <= 1'b1;
      hold         <= 87;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      busy20 <= 1'b0;
      hold20 <= 0;
    end else if (busy20) begin
      if (hold20 == 1) busy20 <= 1'b0;
      hold20 <= hold20 - 1;
    end else if (en20) begin
      busy20 <= 1'b1;
      hold20 <= 87;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      pulses    = 0;
      prev_busy = 1'b0;
    end else begin
      if (uart_tx_en) begin
        en_count++;
        pulses++;
        check("en_while_busy", 32'(uart_tx_busy), 32'd0);
        if (q.size() == 0) check("unexpected_byte", 32'(uart_tx_data), 32'hFFFF_FFFF);
        else               check("frame_byte", 32'(uart_tx_data), 32'(q.pop_front()));
      end
      if (uart_tx_busy && !prev_busy) begin
        check("pulse_per_busy", 32'(pulses), 32'd1);
        pulses = 0;
      end
      prev_busy = uart_tx_busy;
    end
  end

  always @(negedge clk) begin
    if (!rst && en20) begin
      check("en20_while_busy", 32'(busy20), 32'd0);
      if (q20.size() == 0) check("unexpected_byte20", 32'(data20), 32'hFFFF_FFFF);
      else                 check("frame_byte20", 32'(data20), 32'(q20.pop_front()));
    end
  end

  task automatic push(input logic [1:0] ch, input logic [11:0] d, input bit accept);
    logic [15:0] d16;
    logic [7:0]  hdr;
    if (accept) begin
      d16 = {4'h0, d};
      hdr = {m_seq, 2'b00, ch};
      q.push_back(8'hA5);
      q.push_back(hdr);
      q.push_back(d16[15:8]);
      q.push_back(d16[7:0]);
      q.push_back(hdr ^ d16[15:8] ^ d16[7:0]);
      m_seq = m_seq + 4'd1;
    end
    sample_valid = 1'b1;
    sample_chan  = ch;
    sample_data  = d;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic wait_done(input int max, input string tag);
    int n = 0;
    while (!(q.size() == 0 && !frame_busy && fifo_level == 4'd0) && n < max) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < max), 32'd1);
  endtask

  task automatic wait_en(input int target, input int max, input string tag);
    int n = 0;
    while (en_count < target && n < max) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < max), 32'd1);
  endtask

  initial begin
    int base;
    int n;
    rst = 1'b1; enable = 1'b0;
    sample_valid = 1'b0; sample_data = '0; sample_chan = '0;
    v20 = 1'b0; d20 = '0; c20 = '0;
    repeat (3) @(negedge clk);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_ready", 32'(sample_ready), 32'd1);
    check("rst_en", 32'(uart_tx_en), 32'd0);
    check("rst_data", 32'(uart_tx_data), 32'd0);
    check("rst_fbusy", 32'(frame_busy), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0; enable = 1'b1;
    @(negedge clk);

    // Frame 0 with latency: LOAD one cycle after acceptance, en the cycle after.
    push(2'd2, 12'hABC, 1'b1);
    @(negedge clk);
    check("lat_load_fbusy", 32'(frame_busy), 32'd1);
    check("lat_load_en", 32'(uart_tx_en), 32'd0);
    @(negedge clk);
    check("lat_first_en", 32'(uart_tx_en), 32'd1);
    wait_done(1000, "frame0_done");
    check("frame0_pulses", 32'(en_count), 32'd5);

    push(2'd2, 12'hABC, 1'b1);
    wait_done(1000, "frame1_done");
    for (int i = 0; i < 16; i++) begin
      push(2'(i), 12'($urandom_range(0, 4095)), 1'b1);
      wait_done(1000, "wrap_frame_done");
    end
    check("wrap_pulses", 32'(en_count), 32'd90);

    // Fill with enable low; the ninth sample must be dropped.
    enable = 1'b0;
    base = en_count;
    for (int i = 0; i < 9; i++) push(2'(i), 12'(12'h100 + i), i < 8);
    repeat (5) @(negedge clk);
    check("full_level", 32'(fifo_level), 32'd8);
    check("full_ready", 32'(sample_ready), 32'd0);
    check("full_ovf", 32'(overflow), 32'd1);
    check("full_no_en", 32'(en_count), 32'(base));
    enable = 1'b1;
    wait_done(8000, "drain_done");
    check("drain_pulses", 32'(en_count - base), 32'd40);

    // Drop enable during the second byte; the frame must still complete.
    base = en_count;
    for (int i = 0; i < 4; i++) push(2'(i), 12'(12'h5A0 + i), 1'b1);
    wait_en(base + 2, 1000, "byte2_seen");
    enable = 1'b0;
    n = 0;
    while (frame_busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("hold_frame_end", 32'(n < 1000), 32'd1);
    repeat (200) @(negedge clk);
    check("hold_pulses", 32'(en_count - base), 32'd5);
    check("hold_level", 32'(fifo_level), 32'd3);
    check("hold_fbusy", 32'(frame_busy), 32'd0);
    check("hold_queue", 32'(q.size()), 32'd15);

    // Reset while waiting for the transmitter with four samples queued.
    base = en_count;
    enable = 1'b1;
    wait_en(base + 1, 100, "rst_frame_start");
    push(2'd1, 12'h111, 1'b1);
    push(2'd1, 12'h222, 1'b1);
    n = 0;
    while (!uart_tx_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rst_busy_seen", 32'(n < 100), 32'd1);
    repeat (2) @(negedge clk);
    check("pre_rst_level", 32'(fifo_level), 32'd4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    m_seq = 4'd0;
    check("mid_rst_en", 32'(uart_tx_en), 32'd0);
    check("mid_rst_level", 32'(fifo_level), 32'd0);
    check("mid_rst_fbusy", 32'(frame_busy), 32'd0);
    check("mid_rst_ovf", 32'(overflow), 32'd0);
    push(2'd3, 12'h0F0, 1'b1);
    wait_done(1000, "post_rst_done");

    // 20-bit sample without checksum on the second instance.
    q20.push_back(8'hA5);
    q20.push_back(8'h01);
    q20.push_back(8'h0F);
    q20.push_back(8'hED);
    q20.push_back(8'hCB);
    v20 = 1'b1; d20 = 20'hFEDCB; c20 = 2'd1;
    @(negedge clk);
    v20 = 1'b0;
    n = 0;
    while (!(q20.size() == 0 && !fb20) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("w20_done", 32'(n < 1000), 32'd1);
    check("w20_level", 32'(lvl20), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
